// File: rtl/keypad_if.sv
// keypad_if
//   Bundles the keypad matrix pins and the decoded key outputs of the
//   scanner so one handle carries the whole keypad connection.
//   Signals:
//     row_in    [3:0]  keypad rows, active-low, asynchronous to clk
//     col_out   [3:0]  keypad column drive, active-low, one bit low
//     onehot    [15:0] accepted key, bit row*4+col, zero when none
//     key_valid        high while onehot is non-zero
//     key_press        one-cycle strobe for each newly accepted press
//   Modports:
//     master  the scanner (drives columns and key outputs)
//     slave   the keypad/consumer side (drives rows)
interface keypad_if;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] onehot;
  logic        key_valid;
  logic        key_press;

  modport master (
    input  row_in,
    output col_out,
    output onehot,
    output key_valid,
    output key_press
  );

  modport slave (
    output row_in,
    input  col_out,
    input  onehot,
    input  key_valid,
    input  key_press
  );
endinterface

// File: rtl/keypad_scan_debounce.sv
// keypad_scan_debounce
//   Scans a 4x4 active-low matrix keypad one column at a time, rejects
//   ghost/multi-key patterns, debounces press and release, and presents
//   the accepted key as a one-hot code with a one-cycle press strobe.
//   Ports:
//     clk   system clock, all logic on posedge
//     rst   synchronous active-high reset
//     kp    keypad_if.master: row_in in, col_out/onehot/key_valid/key_press out
//   Parameters:
//     SCAN_DIV      cycles each column is driven before rows are judged (>=4)
//     DEBOUNCE_CNT  consecutive stable samples to accept press or release (>=2)
module keypad_scan_debounce #(
  parameter int SCAN_DIV     = 50_000,
  parameter int DEBOUNCE_CNT = 500_000
) (
  input  logic     clk,
  input  logic     rst,
  keypad_if.master kp
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  // The sample that enters DEBOUNCE/RELEASE is the first stable one, so the
  // counter only needs DEBOUNCE_CNT-1 more matches to reach the full count.
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT - 2);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_t;

  state_t           state, state_n;
  logic [DIV_W-1:0] div_cnt, div_n;
  logic [DEB_W-1:0] deb_cnt, deb_n;
  logic [3:0]       col, col_n;
  logic [3:0]       cand_row, cand_row_n;
  logic [1:0]       cand_col, cand_col_n;
  logic [15:0]      onehot_r, onehot_n;
  logic             press_r, press_n;
  logic [3:0]       row_meta, row_s;

  logic             row_single;
  logic             row_idle;
  logic [3:0]       col_rot;

  // Position of the single low bit in an active-low 4-bit pattern.
  function automatic logic [1:0] low_pos(input logic [3:0] v);
    case (v)
      4'b1101: low_pos = 2'd1;
      4'b1011: low_pos = 2'd2;
      4'b0111: low_pos = 2'd3;
      default: low_pos = 2'd0;
    endcase
  endfunction

  // Two-flop synchronizer for the asynchronous row inputs; released rows
  // read high, so reset to all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta <= 4'hF;
      row_s    <= 4'hF;
    end else begin
      row_meta <= kp.row_in;
      row_s    <= row_meta;
    end
  end

  assign row_single = (row_s == 4'b1110) || (row_s == 4'b1101) ||
                      (row_s == 4'b1011) || (row_s == 4'b0111);
  assign row_idle   = (row_s == 4'hF);
  assign col_rot    = {col[2:0], col[3]};

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SCAN;
      div_cnt  <= '0;
      deb_cnt  <= '0;
      col      <= 4'b1110;
      cand_row <= 4'hF;
      cand_col <= 2'd0;
      onehot_r <= '0;
      press_r  <= 1'b0;
    end else begin
      state    <= state_n;
      div_cnt  <= div_n;
      deb_cnt  <= deb_n;
      col      <= col_n;
      cand_row <= cand_row_n;
      cand_col <= cand_col_n;
      onehot_r <= onehot_n;
      press_r  <= press_n;
    end
  end

  // Next-state logic. Rows are only judged at the end of a column's dwell
  // so the synchronizer has flushed the previous column's row pattern.
  always_comb begin
    state_n    = state;
    div_n      = div_cnt;
    deb_n      = deb_cnt;
    col_n      = col;
    cand_row_n = cand_row;
    cand_col_n = cand_col;
    onehot_n   = onehot_r;
    press_n    = 1'b0;

    case (state)
      SCAN: begin
        if (div_cnt == DIV_LAST) begin
          div_n = '0;
          if (row_single) begin
            cand_row_n = row_s;
            cand_col_n = low_pos(col);
            deb_n      = '0;
            state_n    = DEBOUNCE;
          end else begin
            col_n = col_rot;
          end
        end else begin
          div_n = div_cnt + DIV_W'(1);
        end
      end

      DEBOUNCE: begin
        if (row_s == cand_row) begin
          if (deb_cnt == DEB_LAST) begin
            deb_n    = '0;
            onehot_n = 16'd1 << {low_pos(cand_row), cand_col};
            press_n  = 1'b1;
            state_n  = PRESSED;
          end else begin
            deb_n = deb_cnt + DEB_W'(1);
          end
        end else begin
          deb_n   = '0;
          div_n   = '0;
          col_n   = col_rot;
          state_n = SCAN;
        end
      end

      // Extra keys in the held column are deliberately ignored here; only a
      // full release moves on.
      PRESSED: begin
        if (row_idle) begin
          deb_n   = '0;
          state_n = RELEASE;
        end
      end

      RELEASE: begin
        if (row_idle) begin
          if (deb_cnt == DEB_LAST) begin
            deb_n    = '0;
            div_n    = '0;
            col_n    = col_rot;
            onehot_n = '0;
            state_n  = SCAN;
          end else begin
            deb_n = deb_cnt + DEB_W'(1);
          end
        end else begin
          deb_n   = '0;
          state_n = PRESSED;
        end
      end

      default: begin
        state_n = SCAN;
      end
    endcase
  end

  assign kp.col_out   = col;
  assign kp.onehot    = onehot_r;
  assign kp.key_valid = |onehot_r;
  assign kp.key_press = press_r;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// tb_keypad_scan_debounce
//   Directed bench for keypad_scan_debounce with a physical keypad model:
//   the contact vector marks closed switches, and a row reads low when a
//   closed switch sits on the currently driven column. Expected key codes
//   and column sequences are queued when stimulus is applied and popped
//   when the design produces the corresponding output.
module tb_keypad_scan_debounce;
  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] contact = '0;
  logic [3:0]  row_model;

  int checks = 0;
  int passed = 0;
  int failed = 0;
  int press_count = 0;
  bit inv_en = 1'b0;

  logic [31:0] exp_q[$];

  keypad_if kp();

  keypad_scan_debounce #(
    .SCAN_DIV    (SCAN_DIV),
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp (kp)
  );

  always #5 clk = ~clk;

  // Keypad matrix model: closed switch on a driven column pulls its row low.
  always_comb begin
    row_model = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (contact[r*4+c] && !kp.col_out[c]) row_model[r] = 1'b0;
      end
    end
  end

  assign kp.row_in = row_model;

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [15:0] keys);
    contact = keys;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait for a key_press strobe, then compare onehot with the queued code.
  task automatic wait_press(input int budget, input string tag);
    bit seen;
    logic [31:0] exp;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (kp.key_press === 1'b1) seen = 1'b1;
    end
    exp = exp_q.pop_front();
    check_output({tag, "_seen"}, {31'b0, seen}, 32'd1);
    if (seen) check_output(tag, kp.onehot, exp);
  endtask

  // Cycles from now until key_valid drops, or -1 if it never does.
  task automatic release_latency(input int budget, output int lat);
    bit done;
    lat  = -1;
    done = 1'b0;
    for (int k = 1; k <= budget && !done; k++) begin
      @(negedge clk);
      if (kp.key_valid === 1'b0) begin
        lat  = k;
        done = 1'b1;
      end
    end
  endtask

  // Wait for the driven column to move on, proving scanning continues.
  task automatic expect_col_moves(input int budget, input string tag);
    logic [3:0] c0;
    bit moved;
    c0    = kp.col_out;
    moved = 1'b0;
    for (int k = 0; k < budget && !moved; k++) begin
      @(negedge clk);
      if (kp.col_out !== c0) moved = 1'b1;
    end
    check_output(tag, {31'b0, moved}, 32'd1);
  endtask

  // Count strobes at posedge, where the value registered on the prior edge
  // is still visible.
  always @(posedge clk) begin
    if (kp.key_press === 1'b1) press_count++;
  end

  always @(negedge clk) begin
    if (inv_en) begin
      check_output("inv_onehot0", {31'b0, $onehot0(kp.onehot)}, 32'd1);
      check_output("inv_valid", {31'b0, kp.key_valid}, {31'b0, |kp.onehot});
      check_output("inv_col_one_low", $countones(kp.col_out), 32'd3);
    end
  end

  initial begin
    logic [3:0] e;
    int p0;
    int lat;

    $display("[TB] reset");
    apply_stimulus(16'h0000);
    rst = 1'b1;
    idle(2);
    inv_en = 1'b1;
    check_output("rst_col", kp.col_out, 32'h0000_000E);
    check_output("rst_onehot", kp.onehot, 32'h0);
    check_output("rst_valid", kp.key_valid, 32'h0);
    check_output("rst_press", kp.key_press, 32'h0);
    rst = 1'b0;

    $display("[TB] idle scan");
    for (int k = 1; k <= 16; k++) begin
      e = ~(4'b0001 << ((k / 4) % 4));
      exp_q.push_back({28'b0, e});
    end
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check_output("t1_col", kp.col_out, exp_q.pop_front());
    end
    check_output("t1_no_press", press_count, 32'd0);
    check_output("t1_onehot", kp.onehot, 32'h0);

    $display("[TB] row1/col2 press");
    p0 = press_count;
    exp_q.push_back(32'h0000_0040);
    apply_stimulus(16'h0040);
    wait_press(80, "t2_onehot");
    check_output("t2_valid", kp.key_valid, 32'd1);
    check_output("t2_col", kp.col_out, 32'h0000_000B);
    idle(1);
    check_output("t2_pulse_width", kp.key_press, 32'd0);
    idle(20);
    check_output("t2_hold_onehot", kp.onehot, 32'h0000_0040);
    check_output("t2_hold_col", kp.col_out, 32'h0000_000B);
    check_output("t2_one_press", press_count - p0, 32'd1);

    $display("[TB] bouncing release");
    p0 = press_count;
    apply_stimulus(16'h0000);
    idle(5);
    apply_stimulus(16'h0040);
    idle(2);
    check_output("t5_mid_onehot", kp.onehot, 32'h0000_0040);
    apply_stimulus(16'h0000);
    release_latency(40, lat);
    check_output("t5_release_latency", lat, 2 + DEBOUNCE_CNT);
    check_output("t5_onehot_clear", kp.onehot, 32'h0);
    idle(2);
    check_output("t5_no_second_press", press_count - p0, 32'd0);

    $display("[TB] bouncing press");
    p0 = press_count;
    for (int rep = 0; rep < 6; rep++) begin
      apply_stimulus(16'h0200);
      idle(5);
      apply_stimulus(16'h0000);
      idle(5);
    end
    check_output("t3_onehot", kp.onehot, 32'h0);
    check_output("t3_no_press", press_count - p0, 32'd0);
    expect_col_moves(2 * SCAN_DIV + 4, "t3_scan_resumes");

    $display("[TB] ghost row0+row3 in col0");
    p0 = press_count;
    apply_stimulus(16'h1001);
    idle(100);
    check_output("t4_onehot", kp.onehot, 32'h0);
    check_output("t4_no_press", press_count - p0, 32'd0);
    expect_col_moves(2 * SCAN_DIV + 4, "t4_scan_continues");
    apply_stimulus(16'h0000);
    idle(10);

    $display("[TB] reset while held");
    exp_q.push_back(32'h0000_0800);
    apply_stimulus(16'h0800);
    wait_press(80, "t6_first");
    idle(5);
    p0 = press_count;
    rst = 1'b1;
    @(negedge clk);
    check_output("t6_rst_onehot", kp.onehot, 32'h0);
    check_output("t6_rst_col", kp.col_out, 32'h0000_000E);
    check_output("t6_rst_valid", kp.key_valid, 32'd0);
    check_output("t6_rst_press", kp.key_press, 32'd0);
    rst = 1'b0;
    exp_q.push_back(32'h0000_0800);
    wait_press(80, "t6_redetect");
    idle(2);
    check_output("t6_new_press", press_count - p0, 32'd1);
    apply_stimulus(16'h0000);
    release_latency(40, lat);
    check_output("t6_release_latency", lat, 2 + DEBOUNCE_CNT);
    check_output("t6_onehot_clear", kp.onehot, 32'h0);
    idle(4);

    inv_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
